// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution controller: registers one control-transfer op, resolves it in a
// single EVAL cycle and, on a misprediction, holds a fetch redirect until it is accepted.
// Optional feature macro: BRANCH_STATS_EN (adds saturating resolved/mispredict counters).
module branch_resolve_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  func3,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        pred_taken,
    input  logic        kill,
    output logic        done,
    output logic        taken,
    output logic        illegal,
    output logic        misalign,
    output logic [31:0] link_pc,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [1:0]  dbg_state
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredict
`endif
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
    // a redirect transfers with redirect_valid && redirect_ready. Kill suppresses both.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [2:0]  r_func3;
    logic        r_is_jal, r_is_jalr, r_pred, r_taken;
    logic [31:0] r_rs1, r_rs2, r_pc, r_imm, r_redirect_pc;

    logic        cond, taken_c, illegal_c, misalign_c, mispredict_c;
    logic [31:0] target_c, link_c, redir_target_c;

    assign dbg_state = state;

    always_comb begin
        cond = 1'b0;
        case (r_func3)
            3'b000:  cond = (r_rs1 == r_rs2);
            3'b001:  cond = (r_rs1 != r_rs2);
            3'b100:  cond = ($signed(r_rs1) <  $signed(r_rs2));
            3'b101:  cond = ($signed(r_rs1) >= $signed(r_rs2));
            3'b110:  cond = (r_rs1 <  r_rs2);
            3'b111:  cond = (r_rs1 >= r_rs2);
            default: cond = 1'b0;
        endcase
        illegal_c      = (r_func3 == 3'b010) || (r_func3 == 3'b011) || (r_is_jal && r_is_jalr);
        taken_c        = !illegal_c && ((r_is_jal || r_is_jalr) ? 1'b1 : cond);
        target_c       = r_is_jalr ? ((r_rs1 + r_imm) & ~32'd1) : (r_pc + r_imm);
        link_c         = r_pc + 32'd4;
        misalign_c     = taken_c && (target_c[1:0] != 2'b00);
        mispredict_c   = taken_c ^ r_pred;
        redir_target_c = taken_c ? target_c : link_c;
    end

    always_comb begin
        state_next     = state;
        req_ready      = 1'b0;
        done           = 1'b0;
        taken          = 1'b0;
        illegal        = 1'b0;
        misalign       = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !kill && !rst;
                if (req_valid && req_ready) state_next = EVAL;
            end
            EVAL: begin
                if (kill) begin
                    state_next = IDLE;
                end else if (illegal_c || misalign_c || !mispredict_c) begin
                    done       = 1'b1;
                    taken      = taken_c;
                    illegal    = illegal_c;
                    misalign   = misalign_c;
                    state_next = IDLE;
                end else begin
                    state_next = REDIR;
                end
            end
            REDIR: begin
                // Valid is dropped in the kill cycle so a same-cycle ready cannot complete.
                if (kill) begin
                    state_next = IDLE;
                end else begin
                    redirect_valid = 1'b1;
                    if (redirect_ready) begin
                        done       = 1'b1;
                        flush      = 1'b1;
                        taken      = r_taken;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign link_pc     = link_c;
    assign redirect_pc = r_redirect_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            r_func3       <= 3'd0;
            r_is_jal      <= 1'b0;
            r_is_jalr     <= 1'b0;
            r_pred        <= 1'b0;
            r_taken       <= 1'b0;
            r_rs1         <= 32'd0;
            r_rs2         <= 32'd0;
            r_pc          <= 32'd0;
            r_imm         <= 32'd0;
            r_redirect_pc <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid && req_ready) begin
                r_func3   <= func3;
                r_is_jal  <= is_jal;
                r_is_jalr <= is_jalr;
                r_pred    <= pred_taken;
                r_rs1     <= rs1;
                r_rs2     <= rs2;
                r_pc      <= pc;
                r_imm     <= imm;
            end
            if (state == EVAL && state_next == REDIR) begin
                r_redirect_pc <= redir_target_c;
                r_taken       <= taken_c;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved   <= 32'd0;
            stat_mispredict <= 32'd0;
        end else begin
            if (done && stat_resolved != 32'hFFFF_FFFF)
                stat_resolved <= stat_resolved + 32'd1;
            if (flush && stat_mispredict != 32'hFFFF_FFFF)
                stat_mispredict <= stat_mispredict + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 req_valid  in  1  decode presents a control-transfer op.
REQ-004 req_ready  out  1  block accepts op; a transfer occurs when req_valid and req_ready are both 1 on a rising edge.
REQ-005 func3  in  3  branch condition code: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
REQ-006 is_jal, is_jalr  in  1 each  unconditional jump kinds; both 0 means conditional branch; both 1 is illegal.
REQ-007 rs1, rs2, pc, imm  in  32 each  operands, instruction PC, sign-extended immediate.
REQ-008 pred_taken  in  1  fetch-side prediction for this op.
REQ-009 kill  in  1  older-instruction flush; squashes the op in flight.
REQ-010 done  out  1  one-cycle pulse: op resolved; taken, link_pc, illegal and misalign valid only while done=1.
REQ-011 taken, illegal, misalign  out  1 each  resolution result flags.
REQ-012 link_pc  out  32  pc+4 of the resolved op.
REQ-013 redirect_valid  out  1, redirect_ready  in  1, redirect_pc  out  32  fetch redirect handshake.
REQ-014 flush  out  1  one-cycle pulse on redirect handshake; younger ops must be discarded.

Function
REQ-015 FSM states IDLE, EVAL, REDIR; req_ready=1 only in IDLE.
REQ-016 IDLE: on transfer, register all request inputs, go EVAL; otherwise stay IDLE.
REQ-017 EVAL (exactly one cycle): compute from registered operands; signed compares for blt/bge, unsigned for bltu/bgeu.
REQ-018 Taken: branch = condition true; jal/jalr = 1; func3 010/011 or is_jal&is_jalr sets illegal=1, taken=0.
REQ-019 Target: branch/jal = pc+imm; jalr = (rs1+imm) with bit 0 cleared; all adds modulo 2^32, carry discarded; link_pc = pc+4 modulo 2^32.
REQ-020 misalign=1 when taken=1 and target[1:0]!=00; mispredict = taken XOR pred_taken.
REQ-021 EVAL exit: illegal or misalign or no mispredict -> done=1 this cycle, go IDLE, no redirect; else register redirect_pc (target if taken, else link_pc), go REDIR.
REQ-022 REDIR: redirect_valid=1, redirect_pc stable until redirect_ready=1; that cycle done=1, flush=1, go IDLE.
REQ-023 Latency: accept at edge N; non-redirect done in cycle N+1; redirect_valid from cycle N+2, done with handshake.
REQ-024 kill=1 in EVAL or REDIR: go IDLE next edge, no done, no flush, redirect_valid dropped; kill wins over same-cycle redirect_ready; kill in IDLE blocks acceptance (req_ready=0).
REQ-025 Outputs not valid in a cycle are driven 0 (done, flush, redirect_valid, flags); redirect_pc and link_pc are don't-care outside valid cycles.

Reset
REQ-026 rst=1 forces IDLE immediately; done, flush, redirect_valid, taken, illegal, misalign = 0; registered operands and redirect_pc = 0.
REQ-027 Reset mid-EVAL or mid-REDIR abandons the op; no done or flush is produced for it after reset release.

Configuration
REQ-028 Macro BRANCH_STATS_EN defined: adds outputs stat_resolved (32) and stat_mispredict (32); increment on done and on flush respectively, saturate at 0xFFFFFFFF, reset to 0, unaffected by kill.
REQ-029 Macro undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-030 beq rs1=5 rs2=5 pc=0x100 imm=0x20 pred_taken=0 -> redirect_valid at N+2, redirect_pc=0x120, flush+done with ready, taken=1.
REQ-031 blt rs1=0xFFFFFFFF rs2=1 pred_taken=1 -> taken=1, done at N+1, no redirect; bltu same operands -> taken=0, redirect_pc=pc+4.
REQ-032 jalr rs1=0x203 imm=0 -> target 0x202, misalign=1, done at N+1, no redirect, no flush.
REQ-033 func3=010 -> illegal=1, taken=0, no redirect; pc=0xFFFFFFFC -> link_pc=0x00000000.
REQ-034 mispredict with redirect_ready=0 for 3 cycles, then kill and redirect_ready=1 same cycle -> no flush, no done, IDLE next cycle.
REQ-035 rst asserted during REDIR -> redirect_valid=0 immediately; with BRANCH_STATS_EN, counters read 0.
